output_classifier: RTL and testbench



---
 rtl/output_classifier_pkg.sv | 17 +
 rtl/output_classifier_argmax_step.sv | 25 ++
 rtl/output_classifier.sv | 131 +++++++++++++
 tb/tb_output_classifier.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/output_classifier_pkg.sv
// Shared types and sizing helpers for the output-layer argmax classifier.
package output_classifier_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SCAN = 2'd1,
    S_DONE = 2'd2
  } state_e;

  localparam int DROP_CNT_W = 8;

  // Class index width; a single class still needs one bit to carry index 0.
  function automatic int class_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/output_classifier_argmax_step.sv
// One signed argmax comparison: keeps the incumbent on ties so the lowest index wins.
module argmax_step
  import output_classifier_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CW    = 2
) (
  input  logic signed [WIDTH-1:0] best_i,
  input  logic        [CW-1:0]    best_idx_i,
  input  logic signed [WIDTH-1:0] cand_i,
  input  logic        [CW-1:0]    cand_idx_i,
  output logic signed [WIDTH-1:0] best_o,
  output logic        [CW-1:0]    best_idx_o
);

  always_comb begin
    best_o     = best_i;
    best_idx_o = best_idx_i;
    if (cand_i > best_i) begin
      best_o     = cand_i;
      best_idx_o = cand_idx_i;
    end
  end

endmodule

// File: rtl/output_classifier.sv
// Captures an aligned output-layer vector, scans it one class per clock for the
// signed maximum, and holds the decision on a valid/ready handshake.
module output_classifier
  import output_classifier_pkg::*;
#(
  parameter int                      NUM_CLASSES = 3,
  parameter int                      WIDTH       = 8,
  parameter int                      FRAC_BITS   = 5,
  parameter logic signed [WIDTH-1:0] THRESHOLD   = '0,
  localparam int                     CW          = class_w(NUM_CLASSES)
) (
  input  logic                           CLK,
  input  logic                           RST,
  input  logic [NUM_CLASSES*WIDTH-1:0]   VALUES_IN,
  input  logic                           VALID_IN,
  output logic [CW-1:0]                  CLASS_OUT,
  output logic signed [WIDTH-1:0]        SCORE_OUT,
  output logic                           MATCH_OUT,
  output logic [NUM_CLASSES-1:0]         ONEHOT_OUT,
  output logic                           VALID_OUT,
  input  logic                           READY_IN,
  output logic                           BUSY_OUT,
  output logic                           DROP_OUT,
  output logic [DROP_CNT_W-1:0]          DROP_CNT
);

  localparam logic [CW-1:0] LAST_IDX = CW'(NUM_CLASSES - 1);
  localparam bit            SINGLE   = (NUM_CLASSES == 1);

  if (NUM_CLASSES < 1 || FRAC_BITS < 0 || FRAC_BITS >= WIDTH) begin : g_param_check
    $error("output_classifier: NUM_CLASSES must be >= 1 and FRAC_BITS within WIDTH");
  end

  state_e                       state_q, state_d;
  logic [NUM_CLASSES*WIDTH-1:0] vals_q;
  logic signed [WIDTH-1:0]      best_q, cand, step_best, pub_best, first_val, score_q;
  logic [CW-1:0]                best_idx_q, idx_q, step_idx, pub_idx, class_q;
  logic                         capture, drop, publish, match_d, match_q;
  logic [NUM_CLASSES-1:0]       onehot_d, onehot_q;
  logic                         valid_q, busy_q, drop_q;
  logic [DROP_CNT_W-1:0]        drop_cnt_q;

  assign first_val = VALUES_IN[WIDTH-1:0];
  assign cand      = vals_q[int'(idx_q)*WIDTH +: WIDTH];

  // A new vector is taken when idle, or when the held result is being accepted.
  assign capture = VALID_IN && (state_q == S_IDLE || (state_q == S_DONE && READY_IN));
  assign drop    = VALID_IN && !capture;
  assign publish = (state_q == S_SCAN && idx_q == LAST_IDX) || (SINGLE && capture);
  assign pub_best = (state_q == S_SCAN) ? step_best : first_val;
  assign pub_idx  = (state_q == S_SCAN) ? step_idx  : '0;

  argmax_step #(
    .WIDTH (WIDTH),
    .CW    (CW)
  ) u_step (
    .best_i     (best_q),
    .best_idx_i (best_idx_q),
    .cand_i     (cand),
    .cand_idx_i (idx_q),
    .best_o     (step_best),
    .best_idx_o (step_idx)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (capture) state_d = SINGLE ? S_DONE : S_SCAN;
      S_SCAN:  if (idx_q == LAST_IDX) state_d = S_DONE;
      S_DONE:  if (READY_IN) state_d = capture ? (SINGLE ? S_DONE : S_SCAN) : S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    match_d  = (pub_best >= THRESHOLD);
    onehot_d = '0;
    if (match_d) onehot_d[pub_idx] = 1'b1;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q    <= S_IDLE;
      vals_q     <= '0;
      best_q     <= '0;
      best_idx_q <= '0;
      idx_q      <= '0;
      class_q    <= '0;
      score_q    <= '0;
      match_q    <= 1'b0;
      onehot_q   <= '0;
      valid_q    <= 1'b0;
      busy_q     <= 1'b0;
      drop_q     <= 1'b0;
      drop_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      valid_q <= (state_d == S_DONE);
      busy_q  <= (state_d != S_IDLE);
      drop_q  <= drop;
      if (drop && drop_cnt_q != '1) drop_cnt_q <= drop_cnt_q + 1'b1;
      if (capture) begin
        vals_q     <= VALUES_IN;
        best_q     <= first_val;
        best_idx_q <= '0;
        idx_q      <= CW'(1);
      end else if (state_q == S_SCAN) begin
        best_q     <= step_best;
        best_idx_q <= step_idx;
        idx_q      <= idx_q + 1'b1;
      end
      // Result registers move only when a scan completes.
      if (publish) begin
        class_q  <= pub_idx;
        score_q  <= pub_best;
        match_q  <= match_d;
        onehot_q <= onehot_d;
      end
    end
  end

  assign CLASS_OUT  = class_q;
  assign SCORE_OUT  = score_q;
  assign MATCH_OUT  = match_q;
  assign ONEHOT_OUT = onehot_q;
  assign VALID_OUT  = valid_q;
  assign BUSY_OUT   = busy_q;
  assign DROP_OUT   = drop_q;
  assign DROP_CNT   = drop_cnt_q;

endmodule

// File: tb/tb_output_classifier.sv
// Self-checking bench: transaction-level reference model compared every cycle,
// plus directed scenarios with literal expectations.
module tb_output_classifier;

  localparam int N  = 3;
  localparam int W  = 8;
  localparam int CW = 2;
  localparam logic signed [W-1:0] THR = 8'sd0;

  logic           CLK = 1'b0;
  logic           RST = 1'b0;
  logic [N*W-1:0] VALUES_IN = '0;
  logic           VALID_IN = 1'b0;
  logic           READY_IN = 1'b0;
  logic [CW-1:0]  CLASS_OUT;
  logic [W-1:0]   SCORE_OUT;
  logic           MATCH_OUT;
  logic [N-1:0]   ONEHOT_OUT;
  logic           VALID_OUT;
  logic           BUSY_OUT;
  logic           DROP_OUT;
  logic [7:0]     DROP_CNT;

  int checks   = 0;
  int failures = 0;

  always #5 CLK = ~CLK;

  output_classifier #(
    .NUM_CLASSES (N),
    .WIDTH       (W),
    .FRAC_BITS   (5),
    .THRESHOLD   (THR)
  ) dut (
    .CLK        (CLK),
    .RST        (RST),
    .VALUES_IN  (VALUES_IN),
    .VALID_IN   (VALID_IN),
    .CLASS_OUT  (CLASS_OUT),
    .SCORE_OUT  (SCORE_OUT),
    .MATCH_OUT  (MATCH_OUT),
    .ONEHOT_OUT (ONEHOT_OUT),
    .VALID_OUT  (VALID_OUT),
    .READY_IN   (READY_IN),
    .BUSY_OUT   (BUSY_OUT),
    .DROP_OUT   (DROP_OUT),
    .DROP_CNT   (DROP_CNT)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at %0t: actual=%0h required=%0h", nm, $time, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  bit            m_job, m_vld, m_match, m_drop;
  int            m_left, m_cnt;
  logic [CW-1:0] m_jcls, m_cls;
  logic [W-1:0]  m_jscore, m_score;
  logic [N-1:0]  m_oh;

  // Winner = maximum signed score; among equal maxima the lowest index.
  function automatic void ref_argmax(input logic [N*W-1:0] v,
                                     output logic [CW-1:0] c, output logic [W-1:0] s);
    logic signed [W-1:0] mx, e;
    bit found;
    mx = v[W-1:0];
    for (int k = 1; k < N; k++) begin
      e = v[k*W +: W];
      if (e > mx) mx = e;
    end
    found = 0;
    c = '0;
    for (int k = 0; k < N; k++)
      if (!found && v[k*W +: W] == mx) begin c = CW'(k); found = 1; end
    s = mx;
  endfunction

  task automatic model_reset();
    m_job = 0; m_vld = 0; m_left = 0; m_jcls = '0; m_jscore = '0;
    m_cls = '0; m_score = '0; m_match = 0; m_oh = '0; m_drop = 0; m_cnt = 0;
  endtask

  task automatic model_edge();
    bit busy, acc, drp;
    busy = m_job || m_vld;
    acc  = VALID_IN && (!busy || (m_vld && READY_IN));
    drp  = VALID_IN && !acc;
    if (m_vld && READY_IN) m_vld = 0;
    if (m_job) begin
      m_left--;
      if (m_left == 0) begin
        m_job   = 0;
        m_vld   = 1;
        m_cls   = m_jcls;
        m_score = m_jscore;
        m_match = ($signed(m_jscore) >= THR);
        m_oh    = '0;
        if (m_match) m_oh[m_jcls] = 1'b1;
      end
    end
    if (acc) begin
      ref_argmax(VALUES_IN, m_jcls, m_jscore);
      m_job  = 1;
      m_left = N - 1;
    end
    m_drop = drp;
    if (drp && m_cnt < 255) m_cnt++;
  endtask

  always @(posedge CLK) begin
    if (RST) model_reset();
    else model_edge();
    #1;
    chk("valid",   32'(VALID_OUT),  32'(m_vld));
    chk("busy",    32'(BUSY_OUT),   32'(m_job || m_vld));
    chk("class",   32'(CLASS_OUT),  32'(m_cls));
    chk("score",   32'(SCORE_OUT),  32'(m_score));
    chk("match",   32'(MATCH_OUT),  32'(m_match));
    chk("onehot",  32'(ONEHOT_OUT), 32'(m_oh));
    chk("dropout", 32'(DROP_OUT),   32'(m_drop));
    chk("dropcnt", 32'(DROP_CNT),   32'(m_cnt));
  end

  // ---------------- stimulus ----------------
  task automatic send(input logic [N*W-1:0] v);
    VALUES_IN = v;
    VALID_IN  = 1'b1;
    @(negedge CLK);
    VALID_IN  = 1'b0;
  endtask

  task automatic pulse_reset();
    VALID_IN = 1'b0;
    RST = 1'b1;
    @(negedge CLK);
    RST = 1'b0;
  endtask

  function automatic logic [W-1:0] rnd_val();
    logic [W-1:0] pool [6] = '{8'hE0, 8'hF0, 8'h00, 8'h20, 8'h7F, 8'h80};
    if ($urandom_range(0, 1) == 1) return pool[$urandom_range(0, 5)];
    return W'($urandom);
  endfunction

  initial begin
    #1 RST = 1'b1;
    repeat (3) @(negedge CLK);
    chk("rst_valid",   32'(VALID_OUT), 32'h0);
    chk("rst_busy",    32'(BUSY_OUT),  32'h0);
    chk("rst_dropcnt", 32'(DROP_CNT),  32'h0);
    RST = 1'b0;

    // Reset one cycle into a scan: nothing may emerge.
    READY_IN = 1'b1;
    VALUES_IN = {8'hE0, 8'h20, 8'hE0};
    VALID_IN = 1'b1;
    @(negedge CLK);
    VALID_IN = 1'b0;
    RST = 1'b1;
    @(negedge CLK);
    RST = 1'b0;
    chk("midrst_busy", 32'(BUSY_OUT), 32'h0);
    repeat (4) begin
      @(negedge CLK);
      chk("midrst_valid", 32'(VALID_OUT), 32'h0);
    end
    chk("midrst_dropcnt", 32'(DROP_CNT), 32'h0);

    // Basic winner.
    send({8'hE0, 8'h20, 8'hE0});
    repeat (2) @(negedge CLK);
    chk("basic_valid",  32'(VALID_OUT),  32'h1);
    chk("basic_class",  32'(CLASS_OUT),  32'h1);
    chk("basic_score",  32'(SCORE_OUT),  32'h20);
    chk("basic_match",  32'(MATCH_OUT),  32'h1);
    chk("basic_onehot", 32'(ONEHOT_OUT), 32'h2);
    @(negedge CLK);
    chk("basic_vld_drop", 32'(VALID_OUT), 32'h0);

    // Tie between negatives, below threshold.
    send({8'hE0, 8'hF0, 8'hF0});
    repeat (2) @(negedge CLK);
    chk("tie_class",  32'(CLASS_OUT),  32'h0);
    chk("tie_score",  32'(SCORE_OUT),  32'hF0);
    chk("tie_match",  32'(MATCH_OUT),  32'h0);
    chk("tie_onehot", 32'(ONEHOT_OUT), 32'h0);
    @(negedge CLK);

    // Backpressure with a dropped vector mid-hold.
    READY_IN = 1'b0;
    send({8'h30, 8'h05, 8'h10});
    repeat (2) @(negedge CLK);
    for (int c = 0; c < 10; c++) begin
      if (c == 5) begin VALUES_IN = {8'h7F, 8'h7F, 8'h7F}; VALID_IN = 1'b1; end
      @(negedge CLK);
      VALID_IN = 1'b0;
      if (c == 5) begin
        chk("bp_dropout", 32'(DROP_OUT), 32'h1);
        chk("bp_dropcnt", 32'(DROP_CNT), 32'h1);
      end
      chk("bp_valid",  32'(VALID_OUT),  32'h1);
      chk("bp_class",  32'(CLASS_OUT),  32'h2);
      chk("bp_score",  32'(SCORE_OUT),  32'h30);
      chk("bp_onehot", 32'(ONEHOT_OUT), 32'h4);
    end

    // Back-to-back capture on the handshake.
    READY_IN = 1'b1;
    send({8'h7F, 8'h80, 8'h7F});
    chk("b2b_valid0", 32'(VALID_OUT), 32'h0);
    chk("b2b_busy",   32'(BUSY_OUT),  32'h1);
    @(negedge CLK);
    chk("b2b_valid1", 32'(VALID_OUT), 32'h0);
    @(negedge CLK);
    chk("b2b_valid",   32'(VALID_OUT),  32'h1);
    chk("b2b_class",   32'(CLASS_OUT),  32'h0);
    chk("b2b_score",   32'(SCORE_OUT),  32'h7F);
    chk("b2b_onehot",  32'(ONEHOT_OUT), 32'h1);
    chk("b2b_dropcnt", 32'(DROP_CNT),   32'h1);
    @(negedge CLK);

    // Randomized traffic against the model.
    pulse_reset();
    for (int c = 0; c < 1500; c++) begin
      if ($urandom_range(0, 399) == 0) begin
        pulse_reset();
      end else begin
        for (int k = 0; k < N; k++) VALUES_IN[k*W +: W] = rnd_val();
        VALID_IN = ($urandom_range(0, 3) == 0);
        READY_IN = ($urandom_range(0, 3) != 0);
        @(negedge CLK);
      end
    end
    VALID_IN = 1'b0;

    // Drop counter saturation while a result is held.
    pulse_reset();
    READY_IN = 1'b0;
    send({8'h01, 8'h02, 8'h03});
    repeat (2) @(negedge CLK);
    VALID_IN = 1'b1;
    repeat (300) @(negedge CLK);
    VALID_IN = 1'b0;
    @(negedge CLK);
    chk("sat_dropcnt", 32'(DROP_CNT),  32'd255);
    chk("sat_valid",   32'(VALID_OUT), 32'h1);
    chk("sat_score",   32'(SCORE_OUT), 32'h03);
    READY_IN = 1'b1;
    repeat (3) @(negedge CLK);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
